perceptron_layer_sched: RTL and testbench

Time-multiplexed scheduler for one fully-connected perceptron layer in Q32.32 signed fixed point (sfp: 64-bit, 32 fractional bits). It sequences one shared multiply-accumulate over N_IN inputs for each of N_OUT neurons, then routes the result through the activation stage and emits one value per neuron on a ready/valid stream. It sits between the input/weight memories and the next layer. Sigmoid and Tanh are delegated to an external iterative activation unit over a handshake.

---
 rtl/perceptron_layer_sched.sv | 214 +++++++++++++++++++++
 tb/tb_perceptron_layer_sched.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perceptron_layer_sched.sv
// Time-multiplexed Q32.32 perceptron layer scheduler: one shared MAC, external activation handshake.
// Optional macro PERCEPTRON_FAST_ACT_EN computes Step and ReLU internally in a single ACT cycle.
module perceptron_layer_sched #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 3,
    parameter int XAW   = (N_IN > 1) ? $clog2(N_IN) : 1,
    parameter int WAW   = ((N_OUT * (N_IN + 1)) > 1) ? $clog2(N_OUT * (N_IN + 1)) : 1,
    parameter int OAW   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      act_sel,
    output logic            busy,
    output logic            done,
    output logic [XAW-1:0]  x_addr,
    input  logic [63:0]     x_rdata,
    output logic [WAW-1:0]  w_addr,
    input  logic [63:0]     w_rdata,
    output logic            act_valid,
    input  logic            act_ready,
    output logic [63:0]     act_arg,
    output logic [1:0]      act_func,
    input  logic            res_valid,
    input  logic [63:0]     res_data,
    output logic            o_valid,
    input  logic            o_ready,
    output logic [OAW-1:0]  o_idx,
    output logic [63:0]     o_data
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_BIAS  = 3'd1;
    localparam logic [2:0] S_MAC   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_ACT   = 3'd4;
    localparam logic [2:0] S_WRITE = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [63:0]    Q_ONE      = 64'h0000_0001_0000_0000;
    localparam logic [XAW-1:0] K_LAST     = XAW'(N_IN - 1);
    localparam logic [OAW-1:0] N_LAST     = OAW'(N_OUT - 1);
    localparam logic [WAW-1:0] ROW_STRIDE = WAW'(N_IN + 1);

    // Q32.32 multiply: full signed 128-bit product, arithmetic shift by 32, low 64 bits kept.
    function automatic logic [63:0] q_mul(input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] a_ext;
        logic signed [127:0] b_ext;
        logic signed [127:0] prod;
        a_ext = {{64{a[63]}}, a};
        b_ext = {{64{b[63]}}, b};
        prod  = a_ext * b_ext;
        return 64'(prod >>> 32);
    endfunction

    function automatic logic [63:0] fast_act(input logic [1:0] func, input logic [63:0] acc);
        logic [63:0] res;
        case (func)
            2'd0:    res = acc[63] ? 64'd0 : Q_ONE;
            2'd3:    res = acc[63] ? 64'd0 : acc;
            default: res = acc;
        endcase
        return res;
    endfunction

    logic [2:0]     r_state;
    logic [1:0]     r_func;
    logic [OAW-1:0] r_n;
    logic [XAW-1:0] r_k;
    logic [WAW-1:0] r_base;
    logic [XAW-1:0] r_x_addr;
    logic [WAW-1:0] r_w_addr;
    logic [63:0]    r_acc;
    logic [63:0]    r_act_arg;
    logic           r_act_valid;
    logic           r_act_wait;
    logic           r_busy;
    logic           r_done;
    logic           r_o_valid;
    logic [OAW-1:0] r_o_idx;
    logic [63:0]    r_o_data;

    logic [63:0]    w_acc_sum;
    logic           w_fast_fn;

    assign w_acc_sum = r_acc + q_mul(x_rdata, w_rdata);

`ifdef PERCEPTRON_FAST_ACT_EN
    assign w_fast_fn = (r_func == 2'd0) || (r_func == 2'd3);
`else
    assign w_fast_fn = 1'b0;
`endif

    // Sequencer: state, memory addressing, accumulation, activation handshake and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_func      <= 2'd0;
            r_n         <= '0;
            r_k         <= '0;
            r_base      <= '0;
            r_x_addr    <= '0;
            r_w_addr    <= '0;
            r_acc       <= 64'd0;
            r_act_arg   <= 64'd0;
            r_act_valid <= 1'b0;
            r_act_wait  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_o_valid   <= 1'b0;
            r_o_idx     <= '0;
            r_o_data    <= 64'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_func   <= act_sel;
                        r_n      <= '0;
                        r_base   <= '0;
                        r_w_addr <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_BIAS;
                    end
                end
                S_BIAS: begin
                    r_k      <= '0;
                    r_x_addr <= '0;
                    r_w_addr <= r_base + WAW'(1);
                    r_state  <= S_MAC;
                end
                S_MAC: begin
                    // Data arriving in MAC k belongs to the address issued one cycle earlier.
                    if (r_k == '0) begin
                        r_acc <= w_rdata;
                    end else begin
                        r_acc <= w_acc_sum;
                    end
                    if (r_k == K_LAST) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_k      <= r_k + XAW'(1);
                        r_x_addr <= r_k + XAW'(1);
                        r_w_addr <= r_w_addr + WAW'(1);
                    end
                end
                S_DRAIN: begin
                    r_acc       <= w_acc_sum;
                    r_act_arg   <= w_acc_sum;
                    r_act_valid <= !w_fast_fn;
                    r_act_wait  <= 1'b0;
                    r_state     <= S_ACT;
                end
                S_ACT: begin
                    if (w_fast_fn) begin
                        r_o_data  <= fast_act(r_func, r_acc);
                        r_o_idx   <= r_n;
                        r_o_valid <= 1'b1;
                        r_state   <= S_WRITE;
                    end else if (r_act_valid) begin
                        if (act_ready) begin
                            r_act_valid <= 1'b0;
                            r_act_wait  <= 1'b1;
                        end
                    end else if (r_act_wait && res_valid) begin
                        r_act_wait <= 1'b0;
                        r_o_data   <= res_data;
                        r_o_idx    <= r_n;
                        r_o_valid  <= 1'b1;
                        r_state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (o_ready) begin
                        r_o_valid <= 1'b0;
                        if (r_n == N_LAST) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_n      <= r_n + OAW'(1);
                            r_base   <= r_base + ROW_STRIDE;
                            r_w_addr <= r_base + ROW_STRIDE;
                            r_state  <= S_BIAS;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_o_valid   <= 1'b0;
                    r_act_valid <= 1'b0;
                    r_act_wait  <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign x_addr    = r_x_addr;
    assign w_addr    = r_w_addr;
    assign act_valid = r_act_valid;
    assign act_arg   = r_act_arg;
    assign act_func  = r_func;
    assign o_valid   = r_o_valid;
    assign o_idx     = r_o_idx;
    assign o_data    = r_o_data;

endmodule

// File: tb/tb_perceptron_layer_sched.sv
// Scoreboard bench for perceptron_layer_sched (N_IN=4, N_OUT=3) with memory and activation-unit models.
module tb_perceptron_layer_sched;

    localparam int N_IN  = 4;
    localparam int N_OUT = 3;
    localparam int XAW   = 2;
    localparam int WAW   = 4;
    localparam int OAW   = 2;

    localparam logic [63:0] ONE   = 64'h0000_0001_0000_0000;
    localparam logic [63:0] TWO   = 64'h0000_0002_0000_0000;
    localparam logic [63:0] HALF  = 64'h0000_0000_8000_0000;
    localparam logic [63:0] MHALF = 64'hFFFF_FFFF_8000_0000;
    localparam logic [63:0] MQTR  = 64'hFFFF_FFFF_C000_0000;
    localparam logic [63:0] MONE  = 64'hFFFF_FFFF_0000_0000;
    localparam logic [63:0] ONE5  = 64'h0000_0001_8000_0000;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [1:0]     act_sel = 2'd0;
    logic           busy, done, act_valid, o_valid;
    logic [XAW-1:0] x_addr;
    logic [WAW-1:0] w_addr;
    logic [63:0]    x_rdata = 64'd0;
    logic [63:0]    w_rdata = 64'd0;
    logic           act_ready = 1'b0;
    logic [63:0]    act_arg;
    logic [1:0]     act_func;
    logic           res_valid = 1'b0;
    logic [63:0]    res_data = 64'd0;
    logic           o_ready = 1'b1;
    logic [OAW-1:0] o_idx;
    logic [63:0]    o_data;

    perceptron_layer_sched #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .act_sel(act_sel),
        .busy(busy), .done(done),
        .x_addr(x_addr), .x_rdata(x_rdata), .w_addr(w_addr), .w_rdata(w_rdata),
        .act_valid(act_valid), .act_ready(act_ready), .act_arg(act_arg), .act_func(act_func),
        .res_valid(res_valid), .res_data(res_data),
        .o_valid(o_valid), .o_ready(o_ready), .o_idx(o_idx), .o_data(o_data)
    );

    always #5 clk = ~clk;

    logic [63:0] x_mem [4];
    logic [63:0] w_mem [16];

    // Synchronous memories: data valid one cycle after the address.
    always @(posedge clk) begin
        x_rdata <= x_mem[x_addr];
        w_rdata <= w_mem[w_addr];
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [OAW-1:0] idx;
        logic [63:0]    data;
    } exp_t;

    exp_t        sb_q[$];
    logic [63:0] arg_q[$];

    logic [1:0]  cur_func = 2'd0;
    logic [63:0] ext_val  = 64'd0;
    int          rdy_dly  = 0;
    int          res_dly  = 1;
    int          req_cnt  = 0;
    int          done_cnt = 0;

    function automatic logic [63:0] qmul(input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] p;
        p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
        return p[95:32];
    endfunction

    function automatic logic [63:0] ref_acc(input int n);
        logic [63:0] s;
        s = w_mem[n * (N_IN + 1)];
        for (int k = 0; k < N_IN; k++) s = s + qmul(x_mem[k], w_mem[n * (N_IN + 1) + 1 + k]);
        return s;
    endfunction

    function automatic bit ext_needed(input logic [1:0] f);
`ifdef PERCEPTRON_FAST_ACT_EN
        return (f == 2'd1) || (f == 2'd2);
`else
        return 1'b1;
`endif
    endfunction

    task automatic push_exp(input int n, input logic [1:0] f, input logic [63:0] data);
        exp_t e;
        e.idx  = OAW'(n);
        e.data = data;
        sb_q.push_back(e);
        if (ext_needed(f)) arg_q.push_back(ref_acc(n));
    endtask

    task automatic set_row(input int n, input logic [63:0] b, input logic [63:0] w0,
                           input logic [63:0] w1, input logic [63:0] w2, input logic [63:0] w3);
        w_mem[n * 5 + 0] = b;
        w_mem[n * 5 + 1] = w0;
        w_mem[n * 5 + 2] = w1;
        w_mem[n * 5 + 3] = w2;
        w_mem[n * 5 + 4] = w3;
    endtask

    task automatic set_x(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c, input logic [63:0] d);
        x_mem[0] = a; x_mem[1] = b; x_mem[2] = c; x_mem[3] = d;
    endtask

    // Output monitor: pops the scoreboard on each accepted output and checks done pulse width.
    initial begin
        exp_t e;
        logic done_prev;
        done_prev = 1'b0;
        forever begin
            @(negedge clk); #1;
            if (o_valid && o_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_pop_empty", 64'(sb_q.size()), 64'd1);
                end else begin
                    e = sb_q.pop_front();
                    chk("o_idx", 64'(o_idx), 64'(e.idx));
                    chk("o_data", o_data, e.data);
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_width", 64'(done_prev), 64'd0);
            end
            done_prev = done;
        end
    end

    // External activation unit: delayed ready, a stray early result strobe, then the real result.
    initial begin
        logic [63:0] a;
        forever begin
            @(negedge clk);
            res_valid = 1'b0;
            if (act_valid && rst_n) begin
                a = act_arg;
                req_cnt++;
                if (arg_q.size() == 0) chk("arg_q_empty", 64'(arg_q.size()), 64'd1);
                else chk("act_arg", a, arg_q.pop_front());
                chk("act_func", 64'(act_func), 64'(cur_func));
                for (int i = 0; i < rdy_dly; i++) begin
                    res_valid = (i == 1);
                    res_data  = 64'hDEAD_BEEF_DEAD_BEEF;
                    @(negedge clk);
                    chk("act_hold_valid", 64'(act_valid), 64'd1);
                    chk("act_hold_arg", act_arg, a);
                end
                res_valid = 1'b0;
                act_ready = 1'b1;
                @(negedge clk);
                act_ready = 1'b0;
                chk("act_drop", 64'(act_valid), 64'd0);
                for (int i = 1; i < res_dly; i++) @(negedge clk);
                case (cur_func)
                    2'd0:    res_data = a[63] ? 64'd0 : ONE;
                    2'd3:    res_data = a[63] ? 64'd0 : a;
                    default: res_data = ext_val;
                endcase
                res_valid = 1'b1;
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_xaddr"}, 64'(x_addr), 64'd0);
        chk({tag, "_waddr"}, 64'(w_addr), 64'd0);
        chk({tag, "_actv"}, 64'(act_valid), 64'd0);
        chk({tag, "_actarg"}, act_arg, 64'd0);
        chk({tag, "_actfunc"}, 64'(act_func), 64'd0);
        chk({tag, "_ovalid"}, 64'(o_valid), 64'd0);
        chk({tag, "_oidx"}, 64'(o_idx), 64'd0);
        chk({tag, "_odata"}, o_data, 64'd0);
    endtask

    task automatic start_pass(input logic [1:0] f);
        cur_func = f;
        @(negedge clk);
        start   = 1'b1;
        act_sel = f;
        @(negedge clk);
        start   = 1'b0;
        act_sel = ~f;
        chk("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic finish_pass(output int lat);
        int cyc;
        bit seen_v;
        bit prev_hs;
        cyc = 1; seen_v = 1'b0; prev_hs = 1'b0; lat = 0;
        while (!done && cyc < 2000) begin
            if (o_valid && !seen_v) begin
                seen_v = 1'b1;
                lat = cyc;
            end
            prev_hs = o_valid && o_ready;
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", 64'(done), 64'd1);
        chk("done_after_accept", 64'(prev_hs), 64'd1);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_done", 64'(done), 64'd0);
    endtask

    task automatic layer_a();
        set_x(ONE, TWO, 64'd0, 64'd0);
        set_row(0, HALF, ONE, MQTR, 64'd0, 64'd0);
        set_row(1, MHALF, 64'd0, 64'd0, 64'd0, 64'd0);
        set_row(2, HALF, HALF, HALF, 64'd0, 64'd0);
    endtask

    task automatic layer_b();
        set_x(ONE, TWO, MONE, HALF);
        set_row(0, MHALF, 64'd0, 64'd0, 64'd0, 64'd0);
        set_row(1, ONE, MONE, 64'd0, 64'd0, 64'd0);
        set_row(2, 64'd0, 64'd0, ONE5, ONE, TWO);
    endtask

    initial begin
        int lat;
        int req0;
        int dcnt0;
        int cyc;
        logic [63:0] h_data;
        logic [OAW-1:0] h_idx;
        logic [XAW-1:0] h_x;
        logic [WAW-1:0] h_w;

        for (int i = 0; i < 16; i++) w_mem[i] = 64'd0;
        set_x(64'd0, 64'd0, 64'd0, 64'd0);
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // ReLU: sums {1.0, -0.5, 2.0}; first-output latency.
        layer_a();
        push_exp(0, 2'd3, ONE);
        push_exp(1, 2'd3, 64'd0);
        push_exp(2, 2'd3, TWO);
        start_pass(2'd3);
        finish_pass(lat);
`ifdef PERCEPTRON_FAST_ACT_EN
        chk("latency_fast", 64'(lat), 64'd8);
`else
        chk("latency_ext", 64'(lat), 64'd9);
`endif

        // Step: sums {-0.5, 0, 3.0}.
        layer_b();
        push_exp(0, 2'd0, 64'd0);
        push_exp(1, 2'd0, ONE);
        push_exp(2, 2'd0, ONE);
        start_pass(2'd0);
        finish_pass(lat);

        // Tanh via slow external unit with a stray early result strobe.
        rdy_dly = 5; res_dly = 3; ext_val = 64'h0000_0000_C2F7_D2A5;
        req0 = req_cnt;
        for (int n = 0; n < N_OUT; n++) push_exp(n, 2'd2, ext_val);
        start_pass(2'd2);
        finish_pass(lat);
        chk("tanh_requests", 64'(req_cnt - req0), 64'd3);
        rdy_dly = 0; res_dly = 1;

        // Output backpressure with a start pulse during the pass.
        layer_a();
        push_exp(0, 2'd3, ONE);
        push_exp(1, 2'd3, 64'd0);
        push_exp(2, 2'd3, TWO);
        o_ready = 1'b0;
        start_pass(2'd3);
        cyc = 0;
        while (!o_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("bp_valid", 64'(o_valid), 64'd1);
        h_data = o_data; h_idx = o_idx; h_x = x_addr; h_w = w_addr;
        for (int i = 0; i < 10; i++) begin
            start   = (i == 3);
            act_sel = 2'd1;
            @(negedge clk);
            chk("bp_hold_valid", 64'(o_valid), 64'd1);
            chk("bp_hold_data", o_data, h_data);
            chk("bp_hold_idx", 64'(o_idx), 64'(h_idx));
            chk("bp_hold_xaddr", 64'(x_addr), 64'(h_x));
            chk("bp_hold_waddr", 64'(w_addr), 64'(h_w));
        end
        start = 1'b0;
        chk("bp_func_latched", 64'(act_func), 64'd3);
        o_ready = 1'b1;
        @(negedge clk);
        chk("bp_next_base", 64'(w_addr), 64'd5);
        chk("bp_valid_drop", 64'(o_valid), 64'd0);
        finish_pass(lat);

        // Two's complement wrap: 0x7FFFFFFF.0 + 1.0*2.0.
        set_x(ONE, TWO, MONE, HALF);
        for (int n = 0; n < N_OUT; n++) set_row(n, 64'h7FFF_FFFF_0000_0000, TWO, 64'd0, 64'd0, 64'd0);
        for (int n = 0; n < N_OUT; n++) push_exp(n, 2'd3, 64'd0);
        start_pass(2'd3);
        finish_pass(lat);
        rdy_dly = 1; res_dly = 2; ext_val = 64'h0000_0000_0000_1234;
        for (int n = 0; n < N_OUT; n++) begin
            sb_q.push_back('{idx: OAW'(n), data: ext_val});
            arg_q.push_back(64'h8000_0001_0000_0000);
        end
        start_pass(2'd1);
        finish_pass(lat);
        rdy_dly = 0; res_dly = 1;

        // Asynchronous reset during neuron 1 MAC, then a clean pass.
        layer_a();
        push_exp(0, 2'd3, ONE);
        dcnt0 = done_cnt;
        start_pass(2'd3);
        cyc = 0;
        while (!(o_valid && o_ready) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        repeat (3) @(negedge clk);
        chk("pre_reset_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        repeat (2) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt - dcnt0), 64'd0);
        chk("abort_sb_empty", 64'(sb_q.size()), 64'd0);
        rst_n = 1'b1;
        push_exp(0, 2'd3, ONE);
        push_exp(1, 2'd3, 64'd0);
        push_exp(2, 2'd3, TWO);
        start_pass(2'd3);
        finish_pass(lat);
        chk("arg_q_drained", 64'(arg_q.size()), 64'd0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
